// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one load/store at a time, fixed latency,
// byte-lane read-modify-write stores, sign/zero-extended loads, alignment check.
module dmem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic        req_kill,
   output logic        stall,
   output logic        resp_valid,
   output logic [63:0] dmemrd_mem,
   output logic        misalign
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;
   localparam int unsigned QW = AW + 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [QW-1:0]   addr_q;
   logic [63:0]     wdata_q;
   logic [63:0]     mem [DEPTH];

   logic            accept;
   logic            do_access;
   logic [2:0]      off;
   logic [AW-1:0]   idx;
   logic [5:0]      shamt;
   logic [7:0]      size_mask;
   logic [7:0]      byte_en;
   logic [63:0]     bit_mask;
   logic            aligned;
   logic            legal;
   logic [63:0]     word;
   logic [63:0]     lane;
   logic [63:0]     merged;
   logic [63:0]     load_val;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^req_addr[63:QW];

   assign accept    = (state == IDLE) && req_valid && !req_kill;
   assign do_access = (state == BUSY) && !req_kill && (cnt == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = BUSY;
         BUSY: begin
            if (req_kill)          state_nxt = IDLE;
            else if (cnt == '0)    state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational pipeline hold
   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:    stall = req_valid && !req_kill;
         BUSY:    stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   // Request capture and latency counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         cnt     <= CW'(LATENCY - 1);
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr[QW-1:0];
         wdata_q <= req_wdata;
      end else if (state == BUSY && cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Decode, alignment check, lane select and store merge
   always_comb begin
      off   = addr_q[2:0];
      idx   = addr_q[QW-1:3];
      shamt = {off, 3'b000};
      size_mask = 8'h01;
      aligned   = 1'b1;
      case (f3_q[1:0])
         2'b00: begin size_mask = 8'h01; aligned = 1'b1;             end
         2'b01: begin size_mask = 8'h03; aligned = !off[0];          end
         2'b10: begin size_mask = 8'h0F; aligned = (off[1:0] == 2'd0); end
         default: begin size_mask = 8'hFF; aligned = (off == 3'd0);  end
      endcase
      legal   = aligned && (f3_q != 3'b111) && !(we_q && f3_q[2]);
      byte_en = 8'(size_mask << off);
      for (int i = 0; i < 8; i++) bit_mask[i*8 +: 8] = {8{byte_en[i]}};
      word   = mem[idx];
      lane   = word >> shamt;
      merged = (word & ~bit_mask) | ((wdata_q << shamt) & bit_mask);
      case (f3_q)
         3'b000:  load_val = {{56{lane[7]}},  lane[7:0]};
         3'b001:  load_val = {{48{lane[15]}}, lane[15:0]};
         3'b010:  load_val = {{32{lane[31]}}, lane[31:0]};
         3'b011:  load_val = lane;
         3'b100:  load_val = {56'd0, lane[7:0]};
         3'b101:  load_val = {48'd0, lane[15:0]};
         3'b110:  load_val = {32'd0, lane[31:0]};
         default: load_val = 64'd0;
      endcase
   end

   // Storage is not reset; a reset during BUSY suppresses the write
   always_ff @(posedge clk) begin
      if (!rst && do_access && we_q && legal) mem[idx] <= merged;
   end

   // Registered response; results hold until the next completed access
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         dmemrd_mem <= 64'd0;
         misalign   <= 1'b0;
      end else begin
         resp_valid <= do_access;
         if (do_access) begin
            misalign   <= !legal;
            dmemrd_mem <= (legal && !we_q) ? load_val : 64'd0;
         end
      end
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- MEM-stage data-memory responder for the RV64I pipeline.
- Accepts one load/store request at a time from the EX/MEM-side MEM-stage logic and performs the access after a fixed multi-cycle latency.
- Holds the pipeline with `stall` while the access is in flight, then returns sign/zero-extended load data as `dmemrd_mem` for the MEM/WB register.
- Internal DEPTH x 64-bit storage, byte-lane writes, alignment checking.

Parameters:
- DEPTH, 1024: number of 64-bit doublewords; power of two, >=2.
- LATENCY, 2: BUSY cycles per access; 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  MEM-stage instruction is a load or store; held stable while `stall`=1.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV64I width/sign field.
- req_addr  in  64  byte address (ALU result).
- req_wdata  in  64  store data, right-aligned.
- req_kill  in  1  flush: abandon the in-flight request.
- stall  out  1  freeze PC/IF/ID/EX/MEM registers.
- resp_valid  out  1  one-cycle pulse: access complete.
- dmemrd_mem  out  64  load result, extended to 64 bits.
- misalign  out  1  qualifies `resp_valid`: illegal width or misaligned address.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; `resp_valid`=0, `dmemrd_mem`=0, `misalign`=0, counter=0.
  - Storage contents are not reset.
  - Reset in BUSY drops the request; no store is written.
- Index = req_addr[log2(DEPTH)+2:3]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8.
- funct3 decode:
  - 000 B, 001 H, 010 W, 011 D: signed loads / stores.
  - 100 BU, 101 HU, 110 WU: unsigned loads.
  - 111 is illegal.
  - Stores with 100–111 are illegal.
- Alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
- FSM:
  - IDLE:
    - `stall` = req_valid & ~req_kill.
    - On req_valid & ~req_kill: capture we/funct3/addr/wdata, load counter=LATENCY-1, go to BUSY.
  - BUSY:
    - `stall`=1.
    - If req_kill: go to IDLE, no access, no `resp_valid`.
    - Else if counter==0: perform the access and go to RESP.
    - Else: decrement the counter.
  - RESP:
    - `stall`=0; `resp_valid`=1 for exactly this cycle. The pipeline advances at the end of this cycle.
    - Always go to IDLE next; `req_valid` seen in RESP is ignored.
    - The next instruction's request is accepted from IDLE one cycle later.
- Latency: accept at the cycle-0 edge, BUSY for LATENCY cycles, `resp_valid` in cycle LATENCY+1.
- Access, on the BUSY→RESP edge:
  - Load: select the lane by addr[2:0], extend per funct3, register into `dmemrd_mem`.
  - Store: read-modify-write. Only lanes addr[2:0]..addr[2:0]+size-1 take the low bytes of wdata; other bytes are unchanged. `dmemrd_mem`=0.
  - Illegal or misaligned: no read, no write. `dmemrd_mem`=0, `misalign`=1.
  - Legal access: `misalign`=0.
- `dmemrd_mem` and `misalign` hold their values until the next RESP; a killed request does not disturb them.
- `stall` is combinational from state and inputs. `resp_valid`, `dmemrd_mem` and `misalign` are registered.

Test Plan:
- Reset 3 cycles, then idle → `stall`=0, `resp_valid`=0, `dmemrd_mem`=0.
- SD addr 0x10 data 0x8877665544332211, then LD addr 0x10 → `stall` high 3 cycles (LATENCY=2), `resp_valid` in cycle 3, `dmemrd_mem`=0x8877665544332211.
- SB addr 0x13 data 0xAB onto that doubleword, then:
  - LD 0x10 → 0x88776655AB332211.
  - LB 0x13 → 0xFFFFFFFFFFFFFFAB.
  - LBU 0x13 → 0xAB.
  - LW 0x14 → 0xFFFFFFFF88776655.
  - LWU 0x14 → 0x88776655.
- LH addr 0x11; SW addr 0x12; funct3=111 → `resp_valid` with `misalign`=1, `dmemrd_mem`=0; memory unchanged (LD 0x10 still 0x88776655AB332211).
- SD 0x20 data 0x1 with `req_kill` in the 1st BUSY cycle; separately, `rst` in a BUSY cycle → no `resp_valid`, `stall` drops next cycle, LD 0x20 returns the prior value. Repeat with LATENCY=1.
- Addr wrap: SD 0x2000 data 0x55 (DEPTH=1024), then LD 0x0 → 0x55.
